// File: rtl/slink_ll_rx_pkt_router_pkg.sv
// Shared link-layer constants for the RX packet router: data IDs of internal
// packets, attribute FSM encodings and the aux queue word width.
package slink_ll_rx_pkt_router_pkg;

  localparam logic [7:0] IDL_SYM    = 8'h00;
  localparam logic [7:0] NOP_DATAID = 8'h01;
  localparam logic [7:0] ATTR_ADDR  = 8'h04;
  localparam logic [7:0] ATTR_DATA  = 8'h05;
  localparam logic [7:0] ATTR_REQ   = 8'h06;
  localparam logic [7:0] ATTR_RSP   = 8'h07;
  localparam logic [7:0] PX_REQ     = 8'h08;
  localparam logic [7:0] PX_START   = 8'h09;

  localparam logic [0:0] ATTR_ST_IDLE      = 1'b0;
  localparam logic [0:0] ATTR_ST_ADDR_HELD = 1'b1;

  // Aux queue entry is {word_count, data_id}
  localparam int AUX_W = 24;

  function automatic logic isInternalId(input logic [7:0] id);
    return id inside {IDL_SYM, NOP_DATAID, ATTR_ADDR, ATTR_DATA,
                      ATTR_REQ, ATTR_RSP, PX_REQ, PX_START};
  endfunction

endpackage

// File: rtl/slink_ll_rx_aux_fifo.sv
// Small synchronous FIFO for one aux channel. A push into a full queue is
// accepted only when a pop happens in the same cycle.
module slink_ll_rx_aux_fifo
  import slink_ll_rx_pkt_router_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = AUX_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign doPop   = pop_i & ~empty_o;
  assign doPush  = push_i & (~full_o | doPop);
  assign data_o  = empty_o ? '0 : mem_q[rdPtr_q];

  always_comb begin
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; data_o is masked while the queue is empty
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/slink_ll_rx_pkt_router.sv
// RX link-layer router: strips internal packets from the app stream, runs the
// attribute ADDR/DATA/REQ sequencer and steers windowed short packets into aux queues.
module slink_ll_rx_pkt_router
  import slink_ll_rx_pkt_router_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int AUX_DEPTH = 4,
  parameter int OVF_W     = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sop,
  input  logic                    valid,
  input  logic [7:0]              data_id,
  input  logic [15:0]             word_count,
  input  logic                    link_inactive,
  output logic                    sop_app,
  output logic                    valid_app,
  input  logic [NUM_CH-1:0]       filt_en,
  input  logic [8*NUM_CH-1:0]     filt_min,
  input  logic [8*NUM_CH-1:0]     filt_max,
  output logic [15:0]             attr_addr,
  output logic [15:0]             attr_data,
  output logic                    attr_shadow_update,
  output logic                    attr_read_req,
  output logic                    attr_seq_err,
  output logic                    px_req_pkt,
  output logic                    px_start_pkt,
  output logic [2:0]              px_req_state,
  output logic [NUM_CH-1:0]       aux_valid,
  input  logic [NUM_CH-1:0]       aux_ready,
  output logic [AUX_W*NUM_CH-1:0] aux_data,
  output logic [OVF_W*NUM_CH-1:0] aux_ovf_cnt,
  input  logic [NUM_CH-1:0]       aux_ovf_clr
);

  logic        hdr, internalId;
  logic [0:0]  attrState_q, attrState_d;
  logic [15:0] attrAddr_q, attrAddr_d, attrData_q, attrData_d;
  logic        shadow_q, shadow_d, readReq_q, readReq_d, seqErr_q, seqErr_d;
  logic [2:0]  pxState_q, pxState_d;
  logic [NUM_CH-1:0] match;
  logic        matchFound;

  assign hdr          = sop & valid;
  assign internalId   = isInternalId(data_id);
  assign sop_app      = sop & ~internalId;
  assign valid_app    = valid & ~internalId;
  assign px_req_pkt   = hdr & (data_id == PX_REQ);
  assign px_start_pkt = hdr & (data_id == PX_START);

  assign attr_addr          = attrAddr_q;
  assign attr_data          = attrData_q;
  assign attr_shadow_update = shadow_q;
  assign attr_read_req      = readReq_q;
  assign attr_seq_err       = seqErr_q;
  assign px_req_state       = pxState_q;

  // A dropped link abandons any held address, even if a packet arrives that cycle
  always_comb begin
    attrState_d = attrState_q;
    attrAddr_d  = attrAddr_q;
    attrData_d  = attrData_q;
    shadow_d    = 1'b0;
    readReq_d   = 1'b0;
    seqErr_d    = 1'b0;
    if (link_inactive) begin
      attrState_d = ATTR_ST_IDLE;
    end else if (hdr) begin
      case (data_id)
        ATTR_ADDR: begin
          attrAddr_d  = word_count;
          attrState_d = ATTR_ST_ADDR_HELD;
        end
        ATTR_REQ: begin
          attrAddr_d  = word_count;
          readReq_d   = 1'b1;
          attrState_d = ATTR_ST_IDLE;
        end
        ATTR_DATA: begin
          if (attrState_q == ATTR_ST_ADDR_HELD) begin
            attrData_d = word_count;
            shadow_d   = 1'b1;
          end else begin
            seqErr_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pxState_d = pxState_q;
    if (px_req_pkt)         pxState_d = word_count[2:0];
    else if (link_inactive) pxState_d = 3'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      attrState_q <= ATTR_ST_IDLE;
      attrAddr_q  <= '0;
      attrData_q  <= '0;
      shadow_q    <= 1'b0;
      readReq_q   <= 1'b0;
      seqErr_q    <= 1'b0;
      pxState_q   <= '0;
    end else begin
      attrState_q <= attrState_d;
      attrAddr_q  <= attrAddr_d;
      attrData_q  <= attrData_d;
      shadow_q    <= shadow_d;
      readReq_q   <= readReq_d;
      seqErr_q    <= seqErr_d;
      pxState_q   <= pxState_d;
    end
  end

  // Overlapping windows resolve to the lowest channel index
  always_comb begin
    match      = '0;
    matchFound = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!matchFound && hdr && filt_en[i] &&
          (filt_min[8*i +: 8] <= data_id) && (data_id <= filt_max[8*i +: 8])) begin
        match[i]   = 1'b1;
        matchFound = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    logic             full, empty, pop, drop;
    logic [OVF_W-1:0] ovfCnt_q;

    slink_ll_rx_aux_fifo #(.DEPTH(AUX_DEPTH), .WIDTH(AUX_W)) uFifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (match[i]),
      .pop_i   (pop),
      .data_i  ({word_count, data_id}),
      .data_o  (aux_data[AUX_W*i +: AUX_W]),
      .full_o  (full),
      .empty_o (empty)
    );

    assign aux_valid[i] = ~empty;
    assign pop          = aux_valid[i] & aux_ready[i];
    assign drop         = match[i] & full & ~pop;
    assign aux_ovf_cnt[OVF_W*i +: OVF_W] = ovfCnt_q;

    always_ff @(posedge clk) begin
      if (!reset_n)                    ovfCnt_q <= '0;
      else if (aux_ovf_clr[i])         ovfCnt_q <= '0;
      else if (drop && ovfCnt_q != '1) ovfCnt_q <= ovfCnt_q + OVF_W'(1);
    end
  end

endmodule

// File: tb/tb_slink_ll_rx_pkt_router.sv
// Directed bench for the RX packet router: a decode vector table plus
// hand-written sequences for the attribute FSM, PX state and aux queues.
module tb_slink_ll_rx_pkt_router;
  import slink_ll_rx_pkt_router_pkg::*;

  localparam int NUM_CH = 2;
  localparam int AUX_DEPTH = 4;
  localparam int OVF_W = 2;

  logic clk, reset_n, sop, valid, link_inactive;
  logic [7:0] data_id;
  logic [15:0] word_count;
  logic sop_app, valid_app;
  logic [NUM_CH-1:0] filt_en;
  logic [8*NUM_CH-1:0] filt_min, filt_max;
  logic [15:0] attr_addr, attr_data;
  logic attr_shadow_update, attr_read_req, attr_seq_err;
  logic px_req_pkt, px_start_pkt;
  logic [2:0] px_req_state;
  logic [NUM_CH-1:0] aux_valid, aux_ready, aux_ovf_clr;
  logic [24*NUM_CH-1:0] aux_data;
  logic [OVF_W*NUM_CH-1:0] aux_ovf_cnt;

  int testsRun = 0;
  int testsFailed = 0;

  slink_ll_rx_pkt_router #(.NUM_CH(NUM_CH), .AUX_DEPTH(AUX_DEPTH), .OVF_W(OVF_W)) dut (
    .clk(clk), .reset_n(reset_n), .sop(sop), .valid(valid), .data_id(data_id),
    .word_count(word_count), .link_inactive(link_inactive),
    .sop_app(sop_app), .valid_app(valid_app),
    .filt_en(filt_en), .filt_min(filt_min), .filt_max(filt_max),
    .attr_addr(attr_addr), .attr_data(attr_data),
    .attr_shadow_update(attr_shadow_update), .attr_read_req(attr_read_req),
    .attr_seq_err(attr_seq_err), .px_req_pkt(px_req_pkt), .px_start_pkt(px_start_pkt),
    .px_req_state(px_req_state), .aux_valid(aux_valid), .aux_ready(aux_ready),
    .aux_data(aux_data), .aux_ovf_cnt(aux_ovf_cnt), .aux_ovf_clr(aux_ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sop;
    logic       valid;
    logic [7:0] id;
    logic       expSopApp;
    logic       expValidApp;
    logic       expPxReq;
    logic       expPxStart;
  } decodeVec_t;

  decodeVec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic [7:0] id, input logic [15:0] wc);
    sop = s;
    valid = v;
    data_id = id;
    word_count = wc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendHdr(input logic [7:0] id, input logic [15:0] wc);
    applyStimulus(1'b1, 1'b1, id, wc);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    link_inactive = 1'b0;
    filt_en = '0;
    filt_min = '0;
    filt_max = '0;
    aux_ready = '0;
    aux_ovf_clr = '0;
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);

    vecs[0]  = '{1'b1, 1'b1, NOP_DATAID, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, IDL_SYM,    1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, ATTR_ADDR,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, ATTR_DATA,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, ATTR_REQ,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, ATTR_RSP,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, PX_REQ,     1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, PX_START,   1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 8'h2A,      1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, PX_REQ,     1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h2A,      1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, PX_START,   1'b0, 1'b0, 1'b0, 1'b0};

    tick();
    tick();
    checkOutput("rst attr_addr", 32'(attr_addr), 32'h0);
    checkOutput("rst attr_data", 32'(attr_data), 32'h0);
    checkOutput("rst strobes", 32'({attr_shadow_update, attr_read_req, attr_seq_err}), 32'h0);
    checkOutput("rst px_req_state", 32'(px_req_state), 32'h0);
    checkOutput("rst aux_valid", 32'(aux_valid), 32'h0);
    checkOutput("rst aux_ovf_cnt", 32'(aux_ovf_cnt), 32'h0);
    reset_n = 1'b1;

    // Combinational decode and app-stream gating
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].sop, vecs[i].valid, vecs[i].id, 16'h0000);
      #1;
      checkOutput($sformatf("vec%0d sop_app", i), 32'(sop_app), 32'(vecs[i].expSopApp));
      checkOutput($sformatf("vec%0d valid_app", i), 32'(valid_app), 32'(vecs[i].expValidApp));
      checkOutput($sformatf("vec%0d px_req_pkt", i), 32'(px_req_pkt), 32'(vecs[i].expPxReq));
      checkOutput($sformatf("vec%0d px_start_pkt", i), 32'(px_start_pkt), 32'(vecs[i].expPxStart));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
    doReset();

    // Attribute write burst and read request
    sendHdr(ATTR_ADDR, 16'h0123);
    checkOutput("t1 attr_addr", 32'(attr_addr), 32'h0123);
    checkOutput("t1 no update on addr", 32'(attr_shadow_update), 32'h0);
    sendHdr(ATTR_DATA, 16'hBEEF);
    checkOutput("t1 shadow pulse1", 32'(attr_shadow_update), 32'h1);
    checkOutput("t1 attr_data", 32'(attr_data), 32'hBEEF);
    checkOutput("t1 attr_addr held", 32'(attr_addr), 32'h0123);
    tick();
    checkOutput("t1 shadow low", 32'(attr_shadow_update), 32'h0);
    sendHdr(ATTR_DATA, 16'h0001);
    checkOutput("t1 shadow pulse2", 32'(attr_shadow_update), 32'h1);
    checkOutput("t1 attr_data2", 32'(attr_data), 32'h0001);
    checkOutput("t1 no seq_err", 32'(attr_seq_err), 32'h0);
    sendHdr(ATTR_REQ, 16'h0456);
    checkOutput("t1 read_req", 32'(attr_read_req), 32'h1);
    checkOutput("t1 req addr", 32'(attr_addr), 32'h0456);
    tick();
    checkOutput("t1 read_req low", 32'(attr_read_req), 32'h0);
    sendHdr(ATTR_DATA, 16'h7777);
    checkOutput("t1 data after req err", 32'(attr_seq_err), 32'h1);
    checkOutput("t1 data after req kept", 32'(attr_data), 32'h0001);

    // Reset with a header in flight, then orphan DATA
    reset_n = 1'b0;
    applyStimulus(1'b1, 1'b1, ATTR_ADDR, 16'h9999);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("t2 mid-reset addr", 32'(attr_addr), 32'h0);
    checkOutput("t2 mid-reset data", 32'(attr_data), 32'h0);
    reset_n = 1'b1;
    sendHdr(ATTR_DATA, 16'h5555);
    checkOutput("t2 seq_err", 32'(attr_seq_err), 32'h1);
    checkOutput("t2 no shadow", 32'(attr_shadow_update), 32'h0);
    checkOutput("t2 attr_data", 32'(attr_data), 32'h0);
    tick();
    checkOutput("t2 seq_err low", 32'(attr_seq_err), 32'h0);

    // Overlapping windows, lowest index wins
    filt_en = 2'b11;
    filt_min = {8'h28, 8'h20};
    filt_max = {8'h3F, 8'h2F};
    aux_ready = 2'b11;
    applyStimulus(1'b1, 1'b1, 8'h2A, 16'h1111);
    #1;
    checkOutput("t3 sop_app", 32'(sop_app), 32'h1);
    checkOutput("t3 valid_app", 32'(valid_app), 32'h1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("t3 aux_valid 2A", 32'(aux_valid), 32'h1);
    checkOutput("t3 aux_data ch0", 32'(aux_data[23:0]), 32'h11112A);
    tick();
    checkOutput("t3 ch0 popped", 32'(aux_valid), 32'h0);
    sendHdr(8'h30, 16'h2222);
    checkOutput("t3 aux_valid 30", 32'(aux_valid), 32'h2);
    checkOutput("t3 aux_data ch1", 32'(aux_data[47:24]), 32'h222230);
    tick();
    checkOutput("t3 ch1 popped", 32'(aux_valid), 32'h0);
    filt_en = 2'b10;
    sendHdr(8'h2A, 16'h3333);
    checkOutput("t3 ch0 disabled -> ch1", 32'(aux_valid), 32'h2);
    tick();
    filt_en = 2'b11;
    filt_min = {8'h28, 8'h50};
    sendHdr(8'h24, 16'h4444);
    checkOutput("t3 empty window", 32'(aux_valid), 32'h0);
    filt_min = {8'h28, 8'h20};

    // Overflow: six pushes into a four-deep queue
    aux_ready = 2'b00;
    for (int k = 0; k < 6; k++) sendHdr(8'h21, 16'(16'h1000 + k));
    checkOutput("t4 aux_valid", 32'(aux_valid), 32'h1);
    checkOutput("t4 ovf_cnt ch0", 32'(aux_ovf_cnt[1:0]), 32'h2);
    aux_ready = 2'b01;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t4 pop%0d valid", k), 32'(aux_valid[0]), 32'h1);
      checkOutput($sformatf("t4 pop%0d data", k), 32'(aux_data[23:0]), 32'({16'(16'h1000 + k), 8'h21}));
      tick();
    end
    checkOutput("t4 drained", 32'(aux_valid[0]), 32'h0);
    aux_ready = 2'b00;
    aux_ovf_clr = 2'b01;
    tick();
    aux_ovf_clr = 2'b00;
    checkOutput("t4 ovf cleared", 32'(aux_ovf_cnt[1:0]), 32'h0);

    // Full queue with simultaneous push and pop, then saturation
    for (int k = 0; k < 4; k++) sendHdr(8'h22, 16'(16'h00A0 + k));
    aux_ready = 2'b01;
    applyStimulus(1'b1, 1'b1, 8'h22, 16'h00A4);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
    aux_ready = 2'b00;
    checkOutput("t5 no drop on pop", 32'(aux_ovf_cnt[1:0]), 32'h0);
    aux_ready = 2'b01;
    for (int k = 1; k < 5; k++) begin
      checkOutput($sformatf("t5 pop A%0d", k), 32'(aux_data[23:0]), 32'({16'(16'h00A0 + k), 8'h22}));
      tick();
    end
    checkOutput("t5 occupancy was 4", 32'(aux_valid[0]), 32'h0);
    aux_ready = 2'b00;
    for (int k = 0; k < 9; k++) sendHdr(8'h23, 16'(16'h00B0 + k));
    checkOutput("t5 ovf saturated", 32'(aux_ovf_cnt[1:0]), 32'h3);
    checkOutput("t5 head kept", 32'(aux_data[23:0]), 32'h00B023);
    aux_ovf_clr = 2'b01;
    applyStimulus(1'b1, 1'b1, 8'h23, 16'h00CC);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
    aux_ovf_clr = 2'b00;
    checkOutput("t5 clear wins", 32'(aux_ovf_cnt[1:0]), 32'h0);
    sendHdr(8'h23, 16'h00CD);
    checkOutput("t5 count after clear", 32'(aux_ovf_cnt[1:0]), 32'h1);
    checkOutput("t5 ch1 ovf", 32'(aux_ovf_cnt[3:2]), 32'h0);
    link_inactive = 1'b1;
    tick();
    link_inactive = 1'b0;
    checkOutput("t5 kept over link down", 32'(aux_valid[0]), 32'h1);
    aux_ready = 2'b01;
    for (int k = 0; k < 4; k++) tick();
    aux_ready = 2'b00;
    checkOutput("t5 final drain", 32'(aux_valid[0]), 32'h0);

    // PX state and link_inactive interactions
    filt_en = 2'b00;
    applyStimulus(1'b1, 1'b1, PX_REQ, 16'h0003);
    #1;
    checkOutput("t6 px_req_pkt", 32'(px_req_pkt), 32'h1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("t6 px_req_state", 32'(px_req_state), 32'h3);
    tick();
    checkOutput("t6 px hold", 32'(px_req_state), 32'h3);
    link_inactive = 1'b1;
    tick();
    link_inactive = 1'b0;
    checkOutput("t6 px cleared", 32'(px_req_state), 32'h0);
    sendHdr(ATTR_ADDR, 16'h0042);
    link_inactive = 1'b1;
    tick();
    link_inactive = 1'b0;
    checkOutput("t6 addr kept", 32'(attr_addr), 32'h0042);
    sendHdr(ATTR_DATA, 16'h0043);
    checkOutput("t6 seq_err after link down", 32'(attr_seq_err), 32'h1);
    checkOutput("t6 no shadow", 32'(attr_shadow_update), 32'h0);
    sendHdr(ATTR_ADDR, 16'h0050);
    link_inactive = 1'b1;
    applyStimulus(1'b1, 1'b1, ATTR_DATA, 16'h0051);
    tick();
    link_inactive = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("t6 link wins over pkt", 32'(attr_shadow_update), 32'h0);
    checkOutput("t6 link wins data", 32'(attr_data), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
